// File: rtl/mips_pkg.sv
// Shared MIPS definitions: opcode constants, instruction width and fetch-state encoding.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP = 32'h0;

  localparam logic [5:0] OP_R    = 6'd0;
  localparam logic [5:0] OP_LW   = 6'd35;
  localparam logic [5:0] OP_SW   = 6'd43;
  localparam logic [5:0] OP_BEQ  = 6'd4;
  localparam logic [5:0] OP_BNE  = 6'd5;
  localparam logic [5:0] OP_ADDI = 6'h8;
  localparam logic [5:0] OP_ANDI = 6'hC;
  localparam logic [5:0] OP_ORI  = 6'hD;

  // FETCH: request outstanding; HELD: fetched word parked in skid, no request;
  // DRAIN: wrong-path request still in flight, its data will be discarded.
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HELD  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  function automatic logic [5:0] opcode_of(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: clear (bubble) has priority over load, otherwise hold.
module if_id_reg
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               clear,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [ADDR_W-1:0]  pc4_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc4
);

  // Clearing only drops valid; the stale word/pc4 stay put since decode ignores them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      instr <= NOP;
      pc4   <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc4   <= pc4_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, skid buffer for
// decode stalls, and redirect handling including draining an in-flight wrong-path fetch.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               ifid_valid,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc4,
  output logic [5:0]         ifid_opcode
);

  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);

  fetch_state_t       state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_plus4;
  logic [ADDR_W-1:0]  target;
  logic [ADDR_W-1:0]  redir_pc;
  logic [INSTR_W-1:0] skid_instr;
  logic [ADDR_W-1:0]  skid_pc4;

  logic               ifid_load;
  logic               ifid_clear;
  logic [INSTR_W-1:0] ifid_d_instr;
  logic [ADDR_W-1:0]  ifid_d_pc4;

  // pc+4 wraps naturally at the address width; redirect targets are word-aligned.
  assign pc_plus4  = pc + WORD_STEP;
  assign target    = redirect_pc & ALIGN_MASK;
  assign imem_addr = pc;
  // Gating with rst_n keeps the request low for the whole time reset is asserted.
  assign imem_req  = rst_n && (state != HELD);

  // IF/ID control: redirect squashes, an unstalled cycle without new data inserts a bubble.
  always_comb begin
    ifid_load    = 1'b0;
    ifid_clear   = 1'b0;
    ifid_d_instr = imem_rdata;
    ifid_d_pc4   = pc_plus4;
    case (state)
      FETCH: begin
        if (redirect)                ifid_clear = 1'b1;
        else if (imem_ack && !stall) ifid_load  = 1'b1;
        else if (!stall)             ifid_clear = 1'b1;
      end
      HELD: begin
        if (redirect) begin
          ifid_clear = 1'b1;
        end else if (!stall) begin
          ifid_load    = 1'b1;
          ifid_d_instr = skid_instr;
          ifid_d_pc4   = skid_pc4;
        end
      end
      default: ifid_clear = 1'b1;
    endcase
  end

  // Fetch FSM owning the PC, skid buffer and pending redirect target.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      redir_pc   <= '0;
      skid_instr <= NOP;
      skid_pc4   <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ack) begin
            if (redirect) begin
              pc <= target;
            end else begin
              pc <= pc_plus4;
              if (stall) begin
                skid_instr <= imem_rdata;
                skid_pc4   <= pc_plus4;
                state      <= HELD;
              end
            end
          end else if (redirect) begin
            redir_pc <= target;
            state    <= DRAIN;
          end
        end
        HELD: begin
          if (redirect) begin
            pc    <= target;
            state <= FETCH;
          end else if (!stall) begin
            state <= FETCH;
          end
        end
        DRAIN: begin
          if (imem_ack) begin
            pc    <= redirect ? target : redir_pc;
            state <= FETCH;
          end else if (redirect) begin
            redir_pc <= target;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .clear    (ifid_clear),
    .instr_in (ifid_d_instr),
    .pc4_in   (ifid_d_pc4),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc4      (ifid_pc4)
  );

  assign ifid_opcode = opcode_of(ifid_instr);

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// compared every cycle against a transaction-level model of the fetch stage.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic [5:0]  ifid_opcode;

  int checks = 0;
  int passes = 0;

  // Model: a parked word means no request; a squashed request means its data is dropped.
  bit          m_in_reset;
  logic [31:0] m_pc;
  bit          m_squash;
  logic [31:0] m_target;
  bit          m_parked;
  logic [31:0] m_park_instr;
  logic [31:0] m_park_pc4;
  bit          m_valid;
  logic [31:0] m_instr;
  logic [31:0] m_pc4;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ifid_valid  (ifid_valid),
    .ifid_instr  (ifid_instr),
    .ifid_pc4    (ifid_pc4),
    .ifid_opcode (ifid_opcode)
  );

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc       = 32'h0;
    m_squash   = 1'b0;
    m_target   = 32'h0;
    m_parked   = 1'b0;
    m_park_instr = 32'h0;
    m_park_pc4 = 32'h0;
    m_valid    = 1'b0;
    m_instr    = 32'h0;
    m_pc4      = 32'h0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    logic [31:0] tgt;
    logic [31:0] next_pc;
    tgt     = {redirect_pc[31:2], 2'b00};
    next_pc = m_pc + 32'd4;
    if (m_parked) begin
      if (redirect) begin
        m_parked = 1'b0;
        m_pc     = tgt;
        m_valid  = 1'b0;
      end else if (!stall) begin
        m_parked = 1'b0;
        m_valid  = 1'b1;
        m_instr  = m_park_instr;
        m_pc4    = m_park_pc4;
      end
    end else if (m_squash) begin
      m_valid = 1'b0;
      if (imem_ack) begin
        m_pc     = redirect ? tgt : m_target;
        m_squash = 1'b0;
      end else if (redirect) begin
        m_target = tgt;
      end
    end else begin
      if (redirect) begin
        m_valid = 1'b0;
        if (imem_ack) m_pc = tgt;
        else begin
          m_squash = 1'b1;
          m_target = tgt;
        end
      end else if (imem_ack) begin
        if (stall) begin
          m_parked     = 1'b1;
          m_park_instr = imem_rdata;
          m_park_pc4   = next_pc;
        end else begin
          m_valid = 1'b1;
          m_instr = imem_rdata;
          m_pc4   = next_pc;
        end
        m_pc = next_pc;
      end else if (!stall) begin
        m_valid = 1'b0;
      end
    end
  endtask

  // Compare every DUT output with the model.
  task automatic check_output();
    check_val("imem_req",    {31'b0, imem_req},   {31'b0, (!m_in_reset && !m_parked)});
    check_val("imem_addr",   imem_addr,           m_pc);
    check_val("ifid_valid",  {31'b0, ifid_valid}, {31'b0, m_valid});
    check_val("ifid_instr",  ifid_instr,          m_instr);
    check_val("ifid_pc4",    ifid_pc4,            m_pc4);
    check_val("ifid_opcode", {26'b0, ifid_opcode}, {26'b0, m_instr[31:26]});
  endtask

  // Drive one cycle of inputs (called just after a falling edge), clock it, check.
  task automatic apply_stimulus(input logic a, input logic [31:0] d, input logic s,
                                input logic r, input logic [31:0] rp);
    imem_ack    = a;
    imem_rdata  = d;
    stall       = s;
    redirect    = r;
    redirect_pc = rp;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_output();
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    m_in_reset = 1'b0;
    #1;
    check_output();
  endtask

  initial begin
    rst_n       = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    m_in_reset  = 1'b1;
    model_reset();
    @(negedge clk);
    check_output();
    release_reset();
    check_val("t1_req_after_release", {31'b0, imem_req}, 32'd1);
    check_val("t1_addr0", imem_addr, 32'h0);

    // Scenario 1: back-to-back acks.
    apply_stimulus(1'b1, 32'h8C010004, 1'b0, 1'b0, 32'h0);
    check_val("t1_pc4_a", ifid_pc4, 32'h4);
    check_val("t1_opc_lw", {26'b0, ifid_opcode}, 32'd35);
    check_val("t1_addr4", imem_addr, 32'h4);
    apply_stimulus(1'b1, 32'h00221820, 1'b0, 1'b0, 32'h0);
    check_val("t1_pc4_b", ifid_pc4, 32'h8);
    check_val("t1_opc_r", {26'b0, ifid_opcode}, 32'd0);
    check_val("t1_addr8", imem_addr, 32'h8);

    // Scenario 2: ack delayed three cycles at 0x10.
    apply_stimulus(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 32'h10);
    for (int k = 0; k < 3; k++) begin
      check_val("t2_req_wait", {31'b0, imem_req}, 32'd1);
      check_val("t2_addr_wait", imem_addr, 32'h10);
      apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
      check_val("t2_valid_wait", {31'b0, ifid_valid}, 32'd0);
    end
    check_val("t2_req_ack", {31'b0, imem_req}, 32'd1);
    apply_stimulus(1'b1, 32'h20010005, 1'b0, 1'b0, 32'h0);
    check_val("t2_valid", {31'b0, ifid_valid}, 32'd1);
    check_val("t2_pc4", ifid_pc4, 32'h14);
    check_val("t2_addr_next", imem_addr, 32'h14);

    // Scenario 3: stall for three cycles when the ack at 0x20 arrives.
    apply_stimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'h20);
    apply_stimulus(1'b1, 32'h3C0A1234, 1'b1, 1'b0, 32'h0);
    check_val("t3_req_held", {31'b0, imem_req}, 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    check_val("t3_req_held2", {31'b0, imem_req}, 32'd0);
    check_val("t3_pc4_hold", ifid_pc4, 32'h14);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("t3_pc4", ifid_pc4, 32'h24);
    check_val("t3_instr", ifid_instr, 32'h3C0A1234);
    check_val("t3_addr", imem_addr, 32'h24);
    check_val("t3_req", {31'b0, imem_req}, 32'd1);

    // Scenario 4: redirect to 0x100 while the request to 0x30 is outstanding.
    apply_stimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'h30);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h100);
    check_val("t4_addr_stale", imem_addr, 32'h30);
    check_val("t4_valid_d0", {31'b0, ifid_valid}, 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    check_val("t4_valid_d1", {31'b0, ifid_valid}, 32'd0);
    apply_stimulus(1'b1, 32'h8C000000, 1'b0, 1'b0, 32'h0);
    check_val("t4_addr_target", imem_addr, 32'h100);
    check_val("t4_valid_after", {31'b0, ifid_valid}, 32'd0);

    // Scenario 5: redirect with stall while a word is parked.
    apply_stimulus(1'b1, 32'h10000003, 1'b1, 1'b0, 32'h0);
    check_val("t5_req_held", {31'b0, imem_req}, 32'd0);
    apply_stimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h103);
    check_val("t5_valid", {31'b0, ifid_valid}, 32'd0);
    check_val("t5_req", {31'b0, imem_req}, 32'd1);
    check_val("t5_addr", imem_addr, 32'h100);

    // Scenario 6: PC wrap, then reset in the middle of a drain.
    apply_stimulus(1'b1, 32'h0, 1'b0, 1'b1, 32'hFFFFFFFC);
    check_val("t6_addr_top", imem_addr, 32'hFFFFFFFC);
    apply_stimulus(1'b1, 32'h08000001, 1'b0, 1'b0, 32'h0);
    check_val("t6_pc4_wrap", ifid_pc4, 32'h0);
    check_val("t6_addr_wrap", imem_addr, 32'h0);
    apply_stimulus(1'b0, 32'h0, 1'b0, 1'b1, 32'h40);
    rst_n      = 1'b0;
    m_in_reset = 1'b1;
    model_reset();
    #1;
    check_val("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check_val("t6_rst_addr", imem_addr, 32'h0);
    check_val("t6_rst_valid", {31'b0, ifid_valid}, 32'd0);
    check_val("t6_rst_instr", ifid_instr, 32'h0);
    check_val("t6_rst_pc4", ifid_pc4, 32'h0);
    check_output();
    imem_ack = 1'b0;
    redirect = 1'b0;
    release_reset();

    // Randomized traffic: the memory acks only while a request is up.
    for (int i = 0; i < 3000; i++) begin
      logic        a;
      logic [31:0] rp;
      a  = imem_req && ($urandom_range(0, 2) == 0);
      rp = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15)))
                                       : $urandom;
      apply_stimulus(a, $urandom, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 9) == 0), rp);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
